life: RTL and testbench
=======================

LIFE -- requirements
Module: life

Interface
REQ-001 SHALL have parameter X, default 16: board width in cells.
REQ-002 SHALL have parameter Y, default 16: board height in cells.
REQ-003 SHALL have parameter LOG2X, default 4: ceil(log2(X)).
REQ-004 SHALL have parameter LOG2Y, default 4: ceil(log2(Y)).
REQ-005 SHALL have parameter HIGH_BITS, default 32: auto-run prescaler width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port keys, input, 3 bits: encoded command, valid for one clk.
REQ-009 SHALL have port row, output, Y bits: one-hot row strobe.
REQ-010 SHALL have port col, output, X bits: cell states of the strobed row.

Function
REQ-011 SHALL decode keys as: 0 none, 1 up, 2 down, 3 left, 4 right, 5 flip, 6 next, 7 run toggle.
REQ-012 SHALL index cell (x,y) as bit y*X+x of the current-generation array data_low.
REQ-013 SHALL keep a cursor (cx,cy):
- up/down decrement/increment cy; left/right decrement/increment cx.
- the cursor wraps modulo Y and X respectively.
REQ-014 SHALL invert cell (cx,cy) in data_low on flip, effective the next cycle.
REQ-015 SHALL start a generation sweep on next, or on prescaler wrap while in run mode:
- next does nothing while a sweep is already in progress.
- run toggle flips run mode.
- the prescaler counts every clk and wraps at 2^HIGH_BITS.
REQ-016 SHALL evaluate one cell per clk during a sweep, index 0..X*Y-1 ascending:
- neighbours are read from data_low on a torus (edges wrap).
- Conway B3/S23: a live cell with 2 or 3 live neighbours survives; a dead cell with exactly 3 is born.
- each result is written into a separate next-generation buffer.
REQ-017 SHALL copy the next buffer into data_low in the cycle after the last cell, so a sweep takes X*Y+1 cycles.
REQ-018 SHALL ignore up/down/left/right/flip during a sweep.
REQ-019 SHALL scan the display continuously, independent of sweeps:
- a row counter r cycles 0..Y-1, one step per clk.
- row = 1<<r and col = data_low[r*X +: X], with col bit j = cell x=j.
- both outputs are registered.

Reset
REQ-020 SHALL on reset low asynchronously clear:
- the row counter, cursor (0,0), sweep state (idle), run mode (off) and prescaler;
- row and col to all-zero.
REQ-021 SHALL NOT reset data_low or the next buffer, so contents preloaded during reset persist.
REQ-022 SHALL resume operation on the first rising clk edge after reset is released.

Structure
REQ-023 SHALL place the key encodings and sweep-state encodings in a shared package life_pkg.
REQ-024 SHALL hold data_low and the next buffer in one sub-module, life_data, instantiated as l_data_l.
- life_data provides the 3x3 neighbour window, flip write, and the swap.
- the control logic and display scan live in life.

Verification
REQ-025 SHALL cover the plus-shape case:
- stimulus: preload cells (7,8),(8,8),(9,8),(8,7),(8,9), release reset, one next.
- required response: after X*Y+1 cycles, cells x7..9, y7..9 are live except (8,8); all other cells are dead.
REQ-026 SHALL cover the display scan:
- stimulus: the same preload, then observe row/col for Y cycles.
- required response: exactly one row bit set per cycle, stepping 0..15 in order.
- required response: row 8 gives col=16'h0380 and rows 7 and 9 give col=16'h0100.
REQ-027 SHALL cover torus wrap:
- stimulus: blinker at (15,0),(0,0),(1,0), one next.
- required response: cells (0,15),(0,0),(0,1) live, all others dead.
REQ-028 SHALL cover cursor and flip:
- stimulus: reset, then left, up, flip.
- required response: cell (15,15) becomes live.
- follow-up: a second flip clears it.
REQ-029 SHALL cover next during a sweep:
- stimulus: issue next, then next again 10 cycles later.
- required response: exactly one generation advance.
REQ-030 SHALL cover reset mid-sweep:
- stimulus: assert reset low at cycle 100 of a sweep.
- required response: row/col are 0 immediately, the sweep is aborted, and data_low is unchanged.

Source files
------------

// File: rtl/life_pkg.sv
// Shared encodings and the B3/S23 cell rule for the Game of Life board.
package life_pkg;

    localparam int unsigned KEY_W      = 3;
    localparam int unsigned WIN_W      = 9;
    localparam int unsigned WIN_CENTER = 4;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [KEY_W-1:0] {
        KEY_NONE  = 3'd0,
        KEY_UP    = 3'd1,
        KEY_DOWN  = 3'd2,
        KEY_LEFT  = 3'd3,
        KEY_RIGHT = 3'd4,
        KEY_FLIP  = 3'd5,
        KEY_NEXT  = 3'd6,
        KEY_RUN   = 3'd7
    } key_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_SWAP  = 2'd2
    } sweep_e;

    // Next state of the window centre: born on 3, survives on 2 or 3.
    function automatic logic life_rule(input logic [WIN_W-1:0] win);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < WIN_W; i++) begin
            if (i != WIN_CENTER) begin
                cnt = cnt + CNT_W'(win[i]);
            end
        end
        return (cnt == CNT_W'(3)) || (win[WIN_CENTER] && (cnt == CNT_W'(2)));
    endfunction

endpackage

// File: rtl/life_data.sv
// Current/next generation storage with toroidal 3x3 window, flip write and swap.
module life_data
    import life_pkg::*;
#(
    parameter int unsigned X     = 16,
    parameter int unsigned Y     = 16,
    parameter int unsigned LOG2X = 4,
    parameter int unsigned LOG2Y = 4
) (
    input  logic             clk,
    input  logic             flip_en,
    input  logic [LOG2X-1:0] flip_x,
    input  logic [LOG2Y-1:0] flip_y,
    input  logic             wr_en,
    input  logic [LOG2X-1:0] wr_x,
    input  logic [LOG2Y-1:0] wr_y,
    input  logic             wr_val,
    input  logic             swap,
    input  logic [LOG2X-1:0] rd_x,
    input  logic [LOG2Y-1:0] rd_y,
    output logic [WIN_W-1:0] window_c,
    input  logic [LOG2Y-1:0] scan_y,
    output logic [X-1:0]     scan_data_c
);

    // Packed so that cell (x,y) sits at flat bit y*X+x.
    logic [Y-1:0][X-1:0] data_low;
    logic [Y-1:0][X-1:0] data_high;

    logic [LOG2X-1:0] xs [3];
    logic [LOG2Y-1:0] ys [3];

    // Neighbour coordinates wrap at the board edges.
    always_comb begin
        xs[0] = (rd_x == '0) ? LOG2X'(X-1) : rd_x - 1'b1;
        xs[1] = rd_x;
        xs[2] = (rd_x == LOG2X'(X-1)) ? '0 : rd_x + 1'b1;
        ys[0] = (rd_y == '0) ? LOG2Y'(Y-1) : rd_y - 1'b1;
        ys[1] = rd_y;
        ys[2] = (rd_y == LOG2Y'(Y-1)) ? '0 : rd_y + 1'b1;
    end

    // Window bit 3*dy+dx holds cell (x+dx-1, y+dy-1).
    always_comb begin
        window_c = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                window_c[dy*3+dx] = data_low[ys[dy]][xs[dx]];
            end
        end
    end

    assign scan_data_c = data_low[scan_y];

    // Current generation: swap in the finished buffer, else apply a cursor flip.
    always_ff @(posedge clk) begin
        if (swap) begin
            data_low <= data_high;
        end else if (flip_en) begin
            data_low[flip_y][flip_x] <= ~data_low[flip_y][flip_x];
        end
    end

    // Next generation buffer, filled one cell per cycle by the sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_high[wr_y][wr_x] <= wr_val;
        end
    end

endmodule

// File: rtl/life.sv
// Conway's Life on an X-by-Y torus: cursor editing, stepped/auto sweeps, row-scanned display.
module life
    import life_pkg::*;
#(
    parameter int unsigned X         = 16,
    parameter int unsigned Y         = 16,
    parameter int unsigned LOG2X     = 4,
    parameter int unsigned LOG2Y     = 4,
    parameter int unsigned HIGH_BITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] keys,
    output logic [Y-1:0]     row,
    output logic [X-1:0]     col
);

    key_e                 key_c;
    sweep_e               state;
    logic [LOG2X-1:0]     cx;
    logic [LOG2Y-1:0]     cy;
    logic [LOG2X-1:0]     sx;
    logic [LOG2Y-1:0]     sy;
    logic [LOG2Y-1:0]     scan_r;
    logic                 run_mode;
    logic [HIGH_BITS-1:0] prescaler;

    logic             idle_c;
    logic             start_c;
    logic             flip_c;
    logic             wr_en_c;
    logic             swap_c;
    logic             last_c;
    logic             wr_val_c;
    logic [WIN_W-1:0] window_c;
    logic [X-1:0]     scan_data_c;

    assign key_c = key_e'(keys);

    // Command decode; editing and next are only honoured while idle.
    always_comb begin
        idle_c   = (state == ST_IDLE);
        start_c  = idle_c && ((key_c == KEY_NEXT) || (run_mode && (&prescaler)));
        flip_c   = idle_c && (key_c == KEY_FLIP);
        wr_en_c  = (state == ST_SWEEP);
        swap_c   = (state == ST_SWAP);
        last_c   = (sx == LOG2X'(X-1)) && (sy == LOG2Y'(Y-1));
        wr_val_c = life_rule(window_c);
    end

    // Sweep sequencer and cursor: one cell per cycle, then a single swap cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            sx    <= '0;
            sy    <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state <= ST_SWEEP;
                        sx    <= '0;
                        sy    <= '0;
                    end
                    case (key_c)
                        KEY_UP:    cy <= (cy == '0) ? LOG2Y'(Y-1) : cy - 1'b1;
                        KEY_DOWN:  cy <= (cy == LOG2Y'(Y-1)) ? '0 : cy + 1'b1;
                        KEY_LEFT:  cx <= (cx == '0) ? LOG2X'(X-1) : cx - 1'b1;
                        KEY_RIGHT: cx <= (cx == LOG2X'(X-1)) ? '0 : cx + 1'b1;
                        default: ;
                    endcase
                end
                ST_SWEEP: begin
                    if (last_c) begin
                        state <= ST_SWAP;
                    end
                    if (sx == LOG2X'(X-1)) begin
                        sx <= '0;
                        sy <= sy + 1'b1;
                    end else begin
                        sx <= sx + 1'b1;
                    end
                end
                ST_SWAP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Free-running prescaler and run-mode toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            run_mode  <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (key_c == KEY_RUN) begin
                run_mode <= ~run_mode;
            end
        end
    end

    // Display scan: one row per cycle, strobe and row contents registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_r <= '0;
            row    <= '0;
            col    <= '0;
        end else begin
            row    <= Y'(1) << scan_r;
            col    <= scan_data_c;
            scan_r <= (scan_r == LOG2Y'(Y-1)) ? '0 : scan_r + 1'b1;
        end
    end

    life_data #(
        .X     (X),
        .Y     (Y),
        .LOG2X (LOG2X),
        .LOG2Y (LOG2Y)
    ) l_data_l (
        .clk         (clk),
        .flip_en     (flip_c),
        .flip_x      (cx),
        .flip_y      (cy),
        .wr_en       (wr_en_c),
        .wr_x        (sx),
        .wr_y        (sy),
        .wr_val      (wr_val_c),
        .swap        (swap_c),
        .rd_x        (sx),
        .rd_y        (sy),
        .window_c    (window_c),
        .scan_y      (scan_r),
        .scan_data_c (scan_data_c)
    );

endmodule

// File: tb/tb_life.sv
// Self-checking bench for life: key-driven editing against a torus Life model, board read via the display scan.
module tb_life;

    localparam int X  = 16;
    localparam int Y  = 16;
    localparam int HB = 10;

    localparam logic [2:0] K_NONE  = 3'd0;
    localparam logic [2:0] K_UP    = 3'd1;
    localparam logic [2:0] K_DOWN  = 3'd2;
    localparam logic [2:0] K_LEFT  = 3'd3;
    localparam logic [2:0] K_RIGHT = 3'd4;
    localparam logic [2:0] K_FLIP  = 3'd5;
    localparam logic [2:0] K_NEXT  = 3'd6;
    localparam logic [2:0] K_RUN   = 3'd7;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   keys = K_NONE;
    logic [Y-1:0] row;
    logic [X-1:0] col;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int cur_x  = 0;
    int cur_y  = 0;

    bit   [X-1:0] model [Y];
    logic [X-1:0] seen  [Y];

    life #(
        .X         (X),
        .Y         (Y),
        .LOG2X     (4),
        .LOG2Y     (4),
        .HIGH_BITS (HB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .keys  (keys),
        .row   (row),
        .col   (col)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the scan row at edge n is (n-1) mod Y.
    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] k);
        keys = k;
        @(negedge clk);
        keys = K_NONE;
    endtask

    // Key press while idle: the model follows the cursor and flip semantics.
    task automatic idle_key(input logic [2:0] k);
        press(k);
        case (k)
            K_UP:    cur_y = (cur_y + Y - 1) % Y;
            K_DOWN:  cur_y = (cur_y + 1) % Y;
            K_LEFT:  cur_x = (cur_x + X - 1) % X;
            K_RIGHT: cur_x = (cur_x + 1) % X;
            K_FLIP:  model[cur_y][cur_x] = ~model[cur_y][cur_x];
            default: ;
        endcase
    endtask

    task automatic move_to(input int x, input int y);
        int dx;
        int dy;
        dx = (x - cur_x + X) % X;
        dy = (y - cur_y + Y) % Y;
        if (dx <= X/2) repeat (dx) idle_key(K_RIGHT);
        else           repeat (X - dx) idle_key(K_LEFT);
        if (dy <= Y/2) repeat (dy) idle_key(K_DOWN);
        else           repeat (Y - dy) idle_key(K_UP);
    endtask

    task automatic set_cell(input int x, input int y, input bit v);
        if (model[y][x] != v) begin
            move_to(x, y);
            idle_key(K_FLIP);
        end
    endtask

    task automatic clear_model_board();
        for (int y = 0; y < Y; y++)
            for (int x = 0; x < X; x++)
                set_cell(x, y, 1'b0);
    endtask

    // One Conway B3/S23 generation on the torus.
    task automatic step_model();
        bit [X-1:0] nxt [Y];
        int n;
        for (int y = 0; y < Y; y++) begin
            for (int x = 0; x < X; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0)
                            n += int'(model[(y + dy + Y) % Y][(x + dx + X) % X]);
                nxt[y][x] = (n == 3) || (model[y][x] && n == 2);
            end
        end
        for (int y = 0; y < Y; y++) model[y] = nxt[y];
    endtask

    task automatic read_board();
        repeat (Y) begin
            @(negedge clk);
            seen[(edges - 1) % Y] = col;
        end
    endtask

    task automatic compare_board(input string tag);
        read_board();
        for (int y = 0; y < Y; y++)
            check($sformatf("%s_r%0d", tag, y), 64'(seen[y]), 64'(model[y]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        for (int y = 0; y < Y; y++) model[y] = '0;

        // Reset state
        wait_cycles(3);
        check("rst_row", 64'(row), 64'(0));
        check("rst_col", 64'(col), 64'(0));
        reset = 1'b1;

        // Clear whatever the storage powered up with, then confirm empty
        read_board();
        for (int y = 0; y < Y; y++)
            for (int x = 0; x < X; x++)
                if (seen[y][x] === 1'b1) begin
                    move_to(x, y);
                    press(K_FLIP);
                end
        compare_board("clear");

        // Cursor wrap and flip after reset
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        cur_x = 0;
        cur_y = 0;
        idle_key(K_LEFT);
        idle_key(K_UP);
        idle_key(K_FLIP);
        compare_board("flip1");
        check("flip1_cell", 64'(seen[15][15]), 64'(1));
        idle_key(K_FLIP);
        compare_board("flip2");
        check("flip2_cell", 64'(seen[15][15]), 64'(0));

        // Plus shape and display scan
        set_cell(7, 8, 1'b1);
        set_cell(8, 8, 1'b1);
        set_cell(9, 8, 1'b1);
        set_cell(8, 7, 1'b1);
        set_cell(8, 9, 1'b1);
        wait_cycles(1);
        for (int i = 0; i < Y; i++) begin
            @(negedge clk);
            r = (edges - 1) % Y;
            check($sformatf("scan_row%0d", r), 64'(row), 64'(1) << r);
            if (r == 8)           check("scan_col8", 64'(col), 64'h0380);
            if (r == 7 || r == 9) check($sformatf("scan_col%0d", r), 64'(col), 64'h0100);
        end
        press(K_NEXT);
        wait_cycles(X*Y + 1);
        step_model();
        compare_board("plus");
        check("plus_r7", 64'(seen[7]), 64'h0380);
        check("plus_r8", 64'(seen[8]), 64'h0280);
        check("plus_r9", 64'(seen[9]), 64'h0380);

        // Torus wrap: blinker across the x edge
        clear_model_board();
        set_cell(15, 0, 1'b1);
        set_cell(0, 0, 1'b1);
        set_cell(1, 0, 1'b1);
        press(K_NEXT);
        wait_cycles(X*Y + 1);
        step_model();
        compare_board("torus");
        check("torus_r15", 64'(seen[15]), 64'h0001);
        check("torus_r0",  64'(seen[0]),  64'h0001);
        check("torus_r1",  64'(seen[1]),  64'h0001);

        // Second next mid-sweep is ignored; first idle cycle accepts a flip
        press(K_NEXT);
        wait_cycles(9);
        press(K_NEXT);
        wait_cycles(247);
        step_model();
        idle_key(K_FLIP);
        compare_board("dbl_next");

        // Reset at cycle 100 of a sweep
        press(K_NEXT);
        wait_cycles(99);
        reset = 1'b0;
        #1;
        check("midrst_row", 64'(row), 64'(0));
        check("midrst_col", 64'(col), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        cur_x = 0;
        cur_y = 0;
        wait_cycles(X*Y + 10);
        compare_board("midrst");

        // Random boards with ignored keys during the sweep and a flip at the swap boundary
        for (int it = 0; it < 5; it++) begin
            for (int n = 0; n < 25; n++)
                set_cell($urandom_range(0, X-1), $urandom_range(0, Y-1), 1'($urandom_range(0, 1)));
            press(K_NEXT);
            repeat (20) press(3'($urandom_range(1, 6)));
            wait_cycles(X*Y - 20);
            press(K_FLIP);
            step_model();
            idle_key(K_FLIP);
            compare_board($sformatf("rand%0d", it));
        end

        // Run mode held for exactly 2^HB cycles gives exactly one generation
        clear_model_board();
        set_cell(1, 0, 1'b1);
        set_cell(2, 1, 1'b1);
        set_cell(0, 2, 1'b1);
        set_cell(1, 2, 1'b1);
        set_cell(2, 2, 1'b1);
        press(K_RUN);
        wait_cycles((1 << HB) - 1);
        press(K_RUN);
        wait_cycles(X*Y + 10);
        step_model();
        compare_board("run");
        wait_cycles((1 << HB) + 100);
        compare_board("run_off");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
